// File: rtl/cic_gain_normalizer.sv
// cic_gain_normalizer
//
// Normalises the CIC decimator I/Q outputs to OUT_WIDTH. The shift is derived from the
// decimation rate by a small sequential gain calculator. The datapath then rounds half-up,
// selects the bit window and saturates.
//
// Ports:
//   clock, reset           - system clock; asynchronous active-high reset
//   rate_load, dec_rate    - strobe to latch a new decimation rate R and recompute the shift
//   in_strobe, in_i, in_q  - signed accumulator samples (ACC_WIDTH bits)
//   busy                   - gain computation in progress
//   shift                  - right-shift currently applied to new samples
//   out_strobe, out_i/q    - normalised samples, two clocks after in_strobe
//   ovf                    - set with out_strobe when either channel saturated
module cic_gain_normalizer #(
    parameter int unsigned IN_WIDTH    = 16,
    parameter int unsigned OUT_WIDTH   = 16,
    parameter int unsigned N_STAGES    = 5,
    parameter int unsigned RATE_WIDTH  = 8,
    parameter int unsigned ACC_WIDTH   = 56,
    parameter int unsigned SHIFT_WIDTH = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rate_load,
    input  logic [RATE_WIDTH-1:0]  dec_rate,
    input  logic                   in_strobe,
    input  logic [ACC_WIDTH-1:0]   in_i,
    input  logic [ACC_WIDTH-1:0]   in_q,
    output logic                   busy,
    output logic [SHIFT_WIDTH-1:0] shift,
    output logic                   out_strobe,
    output logic [OUT_WIDTH-1:0]   out_i,
    output logic [OUT_WIDTH-1:0]   out_q,
    output logic                   ovf
);

    localparam int unsigned LW       = $clog2(RATE_WIDTH + 1);
    // Reset shift corresponds to R = 8 (three doublings).
    localparam int unsigned ShiftRst = IN_WIDTH + 3 * N_STAGES - OUT_WIDTH;
    localparam int unsigned ShiftMax = ACC_WIDTH - OUT_WIDTH;

    typedef enum logic [1:0] {StIdle, StCalc, StCommit} state_e;

    state_e                 state_q, state_d;
    logic [RATE_WIDTH-1:0]  tmp_q, tmp_d;
    logic [LW-1:0]          l_q, l_d;
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic [31:0]            growth;

    // ---------------------------------------------------------------- gain FSM
    always_comb begin
        state_d = state_q;
        tmp_d   = tmp_q;
        l_d     = l_q;
        shift_d = shift_q;
        growth  = 32'(IN_WIDTH) + 32'(N_STAGES) * 32'(l_q) - 32'(OUT_WIDTH);
        unique case (state_q)
            StIdle: ;
            StCalc: begin
                // Counting shifts of (R-1) until zero yields ceil(log2 R).
                if (tmp_q == '0) begin
                    state_d = StCommit;
                end else begin
                    tmp_d = tmp_q >> 1;
                    l_d   = l_q + LW'(1);
                end
            end
            StCommit: begin
                shift_d = (growth > 32'(ShiftMax)) ? SHIFT_WIDTH'(ShiftMax)
                                                   : SHIFT_WIDTH'(growth);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // A load in any state restarts the calculation; the latest rate wins.
        if (rate_load) begin
            tmp_d   = (dec_rate == '0) ? '0 : dec_rate - RATE_WIDTH'(1);
            l_d     = '0;
            shift_d = shift_q;
            state_d = StCalc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            tmp_q   <= '0;
            l_q     <= '0;
            shift_q <= SHIFT_WIDTH'(ShiftRst);
        end else begin
            state_q <= state_d;
            tmp_q   <= tmp_d;
            l_q     <= l_d;
            shift_q <= shift_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign shift = shift_q;

    // ---------------------------------------------------------------- datapath
    // Round half-up then arithmetic shift, one bit wider than the accumulator so the
    // rounding addend cannot overflow.
    function automatic logic [ACC_WIDTH:0] round_shift(input logic [ACC_WIDTH-1:0]   x,
                                                       input logic [SHIFT_WIDTH-1:0] s);
        logic signed [ACC_WIDTH:0] xe;
        logic signed [ACC_WIDTH:0] half;
        xe   = $signed({x[ACC_WIDTH-1], x});
        half = '0;
        if (s != '0) half = (ACC_WIDTH + 1)'(1) << (s - SHIFT_WIDTH'(1));
        return (xe + half) >>> s;
    endfunction

    // Returns {clamped, value}. The value fits when all bits from the output sign bit
    // upwards agree.
    function automatic logic [OUT_WIDTH:0] saturate(input logic [ACC_WIDTH:0] t);
        logic [ACC_WIDTH-OUT_WIDTH+1:0] top;
        top = t[ACC_WIDTH:OUT_WIDTH-1];
        if ((&top) || (~|top)) return {1'b0, t[OUT_WIDTH-1:0]};
        else if (t[ACC_WIDTH]) return {1'b1, 1'b1, {(OUT_WIDTH - 1){1'b0}}};
        else                   return {1'b1, 1'b0, {(OUT_WIDTH - 1){1'b1}}};
    endfunction

    logic                 v1_q;
    logic [ACC_WIDTH:0]   s1_i_q, s1_q_q, s1_i_d, s1_q_d;
    logic [OUT_WIDTH:0]   sat_i, sat_q;
    logic                 out_strobe_q, ovf_q;
    logic [OUT_WIDTH-1:0] out_i_q, out_q_q;

    always_comb begin
        // Stage 1 uses the shift register's current value, so a simultaneous load
        // still sees the old shift.
        s1_i_d = round_shift(in_i, shift_q);
        s1_q_d = round_shift(in_q, shift_q);
        sat_i  = saturate(s1_i_q);
        sat_q  = saturate(s1_q_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q         <= 1'b0;
            s1_i_q       <= '0;
            s1_q_q       <= '0;
            out_strobe_q <= 1'b0;
            ovf_q        <= 1'b0;
            out_i_q      <= '0;
            out_q_q      <= '0;
        end else begin
            v1_q <= in_strobe;
            if (in_strobe) begin
                s1_i_q <= s1_i_d;
                s1_q_q <= s1_q_d;
            end
            out_strobe_q <= v1_q;
            ovf_q        <= v1_q & (sat_i[OUT_WIDTH] | sat_q[OUT_WIDTH]);
            if (v1_q) begin
                out_i_q <= sat_i[OUT_WIDTH-1:0];
                out_q_q <= sat_q[OUT_WIDTH-1:0];
            end
        end
    end

    assign out_strobe = out_strobe_q;
    assign out_i      = out_i_q;
    assign out_q      = out_q_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_cic_gain_normalizer.sv
// Testbench for cic_gain_normalizer at default parameters. Expected samples go into a
// queue and are checked by an independent output monitor.
module tb_cic_gain_normalizer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rate_load = 1'b0;
    logic [7:0]  dec_rate = '0;
    logic        in_strobe = 1'b0;
    logic [55:0] in_i = '0;
    logic [55:0] in_q = '0;
    logic        busy;
    logic [5:0]  shift;
    logic        out_strobe;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic        ovf;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic        o;
        int          due;
    } exp_t;

    exp_t sb[$];

    cic_gain_normalizer dut (
        .clock      (clock),
        .reset      (reset),
        .rate_load  (rate_load),
        .dec_rate   (dec_rate),
        .in_strobe  (in_strobe),
        .in_i       (in_i),
        .in_q       (in_q),
        .busy       (busy),
        .shift      (shift),
        .out_strobe (out_strobe),
        .out_i      (out_i),
        .out_q      (out_q),
        .ovf        (ovf)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Output monitor: every out_strobe must match the head of the queue, on time.
    always @(negedge clock) begin
        exp_t e;
        if (out_strobe) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got sample i=%h q=%h at cyc %0d, expected none",
                         out_i, out_q, cyc);
            end else begin
                e = sb.pop_front();
                if (out_i !== e.i || out_q !== e.q || ovf !== e.o || cyc != e.due) begin
                    errors++;
                    $display("FAIL out_sample: got i=%h q=%h ovf=%b cyc=%0d, expected i=%h q=%h ovf=%b cyc=%0d",
                             out_i, out_q, ovf, cyc, e.i, e.q, e.o, e.due);
                end
            end
        end else if (ovf !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL ovf_idle: got ovf=%b without out_strobe, expected 0", ovf);
        end
    end

    // Drive one sample for one cycle and queue its expected result.
    task automatic send(input longint xi, input longint xq,
                        input logic [15:0] ei, input logic [15:0] eq, input logic eo);
        exp_t e;
        in_strobe = 1'b1;
        in_i      = 56'(xi);
        in_q      = 56'(xq);
        e.i   = ei;
        e.q   = eq;
        e.o   = eo;
        e.due = cyc + 2;
        sb.push_back(e);
        @(posedge clock); #1;
        in_strobe = 1'b0;
    endtask

    task automatic load(input logic [7:0] r, input int exp_busy, input logic [5:0] exp_shift);
        logic [5:0] prev;
        int         n;
        bit         held;
        prev = shift;
        held = 1'b1;
        n    = 0;
        rate_load = 1'b1;
        dec_rate  = r;
        @(posedge clock); #1;
        rate_load = 1'b0;
        while (busy && n < 64) begin
            n++;
            if (shift !== prev) held = 1'b0;
            @(posedge clock); #1;
        end
        check($sformatf("busy_cycles_R%0d", r), n, exp_busy);
        check($sformatf("shift_hold_R%0d", r), held, 1);
        check($sformatf("shift_R%0d", r), shift, exp_shift);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int ek;
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("por_shift", shift, 15);
        check("por_busy", busy, 0);
        check("por_out_strobe", out_strobe, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Rounding and saturation at shift = 15.
        send(49152, -49152, 16'd2, 16'hFFFF, 1'b0);
        send(16383, 0, 16'd0, 16'd0, 1'b0);
        send(longint'(1) << 31, -(longint'(1) << 31) - 65536, 16'h7FFF, 16'h8000, 1'b1);
        send(longint'(32767) * 32768 + 16384, -longint'(32768) * 32768, 16'h7FFF, 16'h8000, 1'b1);
        send(longint'(32767) * 32768 + 16383, -longint'(32768) * 32768 - 16384,
             16'h7FFF, 16'h8000, 1'b0);
        send(0, -longint'(32768) * 32768 - 16385, 16'd0, 16'h8000, 1'b1);
        repeat (4) @(posedge clock);
        #1;

        // Gain computation for power-of-two, odd and degenerate rates.
        load(8'd128, 9, 6'd35);
        load(8'd8, 5, 6'd15);
        load(8'd100, 9, 6'd35);
        load(8'd255, 10, 6'd40);
        load(8'd1, 2, 6'd0);
        send(12345, -5, 16'd12345, 16'hFFFB, 1'b0);
        send(40000, -32768, 16'h7FFF, 16'h8000, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        load(8'd0, 2, 6'd0);

        // Reload while busy: the second rate wins.
        rate_load = 1'b1;
        dec_rate  = 8'd200;
        @(posedge clock); #1;
        rate_load = 1'b0;
        @(posedge clock); #1;
        load(8'd16, 6, 6'd20);

        // Continuous stream through an R=8 -> R=16 load issued with sample 2.
        // New shift lands 7 cycles after sample 2 is driven, i.e. from sample 9 on.
        load(8'd8, 5, 6'd15);
        for (int k = 0; k < 12; k++) begin
            ek = (k <= 8) ? 32 * (k + 1) : k + 1;
            if (k == 2) begin
                rate_load = 1'b1;
                dec_rate  = 8'd16;
            end
            send(longint'(k + 1) << 20, -(longint'(k + 1) << 20), 16'(ek), 16'(-ek), 1'b0);
            rate_load = 1'b0;
        end
        repeat (4) @(posedge clock);
        #1;
        check("stream_shift", shift, 20);
        check("stream_busy", busy, 0);

        // Asynchronous reset mid-cycle while busy and with a sample in flight.
        rate_load = 1'b1;
        dec_rate  = 8'd255;
        in_strobe = 1'b1;
        in_i      = 56'(longint'(1) << 30);
        in_q      = '0;
        @(posedge clock); #1;
        rate_load = 1'b0;
        in_strobe = 1'b0;
        check("pre_reset_busy", busy, 1);
        #3 reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_shift", shift, 15);
        check("rst_out_strobe", out_strobe, 0);
        check("rst_out_i", out_i, 0);
        check("rst_out_q", out_q, 0);
        check("rst_ovf", ovf, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("queue_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
